// File: rtl/tube_pkg.sv
// Shared tube definitions: arbiter state encoding, source indices, enable register layout.
package tube_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CFG_W   = 5;

  // Source indices into src_avail / irq_en
  localparam logic [IDX_W-1:0] SRC_R1 = 2'd0;
  localparam logic [IDX_W-1:0] SRC_R2 = 2'd1;
  localparam logic [IDX_W-1:0] SRC_R3 = 2'd2;
  localparam logic [IDX_W-1:0] SRC_R4 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2
  } arb_state_e;

  // Enable register: NMI enable for R3 on top, per-source IRQ enables below
  typedef struct packed {
    logic               nmi_en;
    logic [NUM_SRC-1:0] irq_en;
  } cfg_t;

  // Next source index with natural 3 -> 0 wrap
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/tube_rr_pick4.sv
// Rotating-priority pick over four requests, searching from ptr upward modulo 4.
module tube_rr_pick4
  import tube_pkg::*;
(
  input  logic [NUM_SRC-1:0] request,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant_idx_c,
  output logic               any_c
);

  logic [IDX_W-1:0] idx;

  // First set request at ptr, ptr+1, ... wins; idx wraps in its 2-bit width
  always_comb begin
    grant_idx_c = ptr;
    any_c       = 1'b0;
    idx         = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = ptr + IDX_W'(k);
      if (!any_c && request[idx]) begin
        grant_idx_c = idx;
        any_c       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tube_p2_int_arb.sv
// Parasite-side interrupt arbiter: round-robin IRQ over four sources plus R3 NMI.
module tube_p2_int_arb
  import tube_pkg::*;
#(
  parameter int unsigned HOLDOFF = 3
) (
  input  logic               p2_clk,
  input  logic               rst_b,
  input  logic [NUM_SRC-1:0] src_avail,
  input  logic               cfg_we,
  input  logic [CFG_W-1:0]   cfg_wdata,
  input  logic               int_ack,
  output logic               p2_irq_b,
  output logic               p2_nmi_b,
  output logic [IDX_W-1:0]   vec,
  output logic               vec_valid,
  output logic [CFG_W-1:0]   cfg_q
);

  localparam int unsigned CNT_W = (HOLDOFF == 0) ? 1 : $clog2(HOLDOFF + 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] vec_q, vec_d;
  logic             vld_q, vld_d;
  logic             irq_b_q, irq_b_d;
  logic             nmi_b_q;
  cfg_t             cfg_r;

  logic [NUM_SRC-1:0] eligible;
  logic [IDX_W-1:0]   grant_idx_c;
  logic               any_c;

  assign eligible = src_avail & cfg_r.irq_en;

  tube_rr_pick4 u_pick (
    .request     (eligible),
    .ptr         (ptr_q),
    .grant_idx_c (grant_idx_c),
    .any_c       (any_c)
  );

  // Enable register; a write takes effect on eligibility from the following cycle
  always_ff @(posedge p2_clk or negedge rst_b) begin
    if (!rst_b) begin
      cfg_r <= '0;
    end else if (cfg_we) begin
      cfg_r <= cfg_t'(cfg_wdata);
    end
  end

  // NMI follows R3 availability gated by nmi_en, independent of the IRQ FSM
  always_ff @(posedge p2_clk or negedge rst_b) begin
    if (!rst_b) begin
      nmi_b_q <= 1'b1;
    end else begin
      nmi_b_q <= !(cfg_r.nmi_en & src_avail[SRC_R3]);
    end
  end

  // FSM and grant state registers
  always_ff @(posedge p2_clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      vld_q   <= 1'b0;
      irq_b_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      vld_q   <= vld_d;
      irq_b_q <= irq_b_d;
    end
  end

  // Next-state: grant in IDLE, wait for ack/withdrawal in ASSERT, count down in HOLD
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    vld_d   = vld_q;
    irq_b_d = irq_b_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          vec_d   = grant_idx_c;
          vld_d   = 1'b1;
          irq_b_d = 1'b0;
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        // Ack wins over a simultaneous withdrawal
        if (int_ack) begin
          irq_b_d = 1'b1;
          vld_d   = 1'b0;
          ptr_d   = next_idx(vec_q);
          cnt_d   = CNT_W'(HOLDOFF);
          state_d = ST_HOLD;
        end else if (!eligible[vec_q]) begin
          irq_b_d = 1'b1;
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // Leaving on count 1 (or 0) gives HOLDOFF cycles here, minimum one
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign p2_irq_b  = irq_b_q;
  assign p2_nmi_b  = nmi_b_q;
  assign vec       = vec_q;
  assign vec_valid = vld_q;
  assign cfg_q     = cfg_r;

endmodule

// File: tb/tb_tube_p2_int_arb.sv
// Self-checking bench for tube_p2_int_arb: directed scenarios plus randomized traffic vs a reference model.
module tb_tube_p2_int_arb;

  localparam int unsigned HOLDOFF = 3;

  logic       p2_clk;
  logic       rst_b;
  logic [3:0] src_avail;
  logic       cfg_we;
  logic [4:0] cfg_wdata;
  logic       int_ack;
  logic       p2_irq_b;
  logic       p2_nmi_b;
  logic [1:0] vec;
  logic       vec_valid;
  logic [4:0] cfg_q;

  int checks;
  int failures;

  // Reference model state: live grant flag, granted index, search start, hold cycles left
  bit       m_busy;
  int       m_vec;
  int       m_ptr;
  int       m_hold;
  bit [4:0] m_cfg;
  bit       m_nmi_b;

  tube_p2_int_arb #(.HOLDOFF(HOLDOFF)) dut (
    .p2_clk    (p2_clk),
    .rst_b     (rst_b),
    .src_avail (src_avail),
    .cfg_we    (cfg_we),
    .cfg_wdata (cfg_wdata),
    .int_ack   (int_ack),
    .p2_irq_b  (p2_irq_b),
    .p2_nmi_b  (p2_nmi_b),
    .vec       (vec),
    .vec_valid (vec_valid),
    .cfg_q     (cfg_q)
  );

  initial p2_clk = 1'b0;
  always #5 p2_clk = ~p2_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_vec   = 0;
    m_ptr   = 0;
    m_hold  = 0;
    m_cfg   = '0;
    m_nmi_b = 1'b1;
  endfunction

  // One clock edge of the arbiter rules, using inputs and configuration from before the edge
  function automatic void model_edge();
    bit [3:0] elig;
    int       idx;
    elig    = src_avail & m_cfg[3:0];
    m_nmi_b = !(m_cfg[4] && src_avail[2]);
    if (m_hold > 0) begin
      m_hold = m_hold - 1;
    end else if (m_busy) begin
      if (int_ack) begin
        m_busy = 1'b0;
        m_ptr  = (m_vec + 1) % 4;
        m_hold = (HOLDOFF == 0) ? 1 : int'(HOLDOFF);
      end else if (!elig[m_vec]) begin
        m_busy = 1'b0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (!m_busy && elig[idx]) begin
          m_busy = 1'b1;
          m_vec  = idx;
        end
      end
    end
    if (cfg_we) m_cfg = cfg_wdata;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".irq_b"}, 32'(p2_irq_b), 32'(!m_busy));
    check({tag, ".vec_valid"}, 32'(vec_valid), 32'(m_busy));
    check({tag, ".vec"}, 32'(vec), 32'(m_vec));
    check({tag, ".nmi_b"}, 32'(p2_nmi_b), 32'(m_nmi_b));
    check({tag, ".cfg_q"}, 32'(cfg_q), 32'(m_cfg));
  endtask

  task automatic tick(input string tag);
    @(posedge p2_clk);
    if (!rst_b) model_reset();
    else model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic write_cfg(input logic [4:0] val);
    cfg_we    = 1'b1;
    cfg_wdata = val;
    tick("cfg_wr");
    cfg_we    = 1'b0;
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    tick("ack");
    int_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    model_reset();
    #1;
    compare_all("reset_async");
    tick("reset_hold");
    rst_b = 1'b1;
  endtask

  task automatic wait_grant(input string tag);
    for (int t = 0; t < 12 && p2_irq_b !== 1'b0; t++) tick(tag);
    check({tag, ".granted"}, 32'(p2_irq_b), 32'(0));
  endtask

  int exp_seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    checks    = 0;
    failures  = 0;
    src_avail = '0;
    cfg_we    = 1'b0;
    cfg_wdata = '0;
    int_ack   = 1'b0;
    rst_b     = 1'b1;
    model_reset();
    #2;
    do_reset();
    check("rst.irq_b", 32'(p2_irq_b), 32'(1));
    check("rst.cfg_q", 32'(cfg_q), 32'(0));

    // No grant after reset until a source is enabled
    src_avail = 4'b1111;
    for (int i = 0; i < 3; i++) tick("no_cfg");
    check("no_cfg.irq_b", 32'(p2_irq_b), 32'(1));

    // Single source: grant, ack, re-grant exactly four edges after the ack edge
    src_avail = 4'b0001;
    write_cfg(5'h0F);
    tick("single_grant");
    check("single.irq_low", 32'(p2_irq_b), 32'(0));
    check("single.vec0", 32'(vec), 32'(0));
    ack_pulse();
    check("single.ack_irq_high", 32'(p2_irq_b), 32'(1));
    for (int i = 0; i < 3; i++) begin
      tick("holdoff");
      check("holdoff.irq_high", 32'(p2_irq_b), 32'(1));
    end
    tick("regrant");
    check("regrant.irq_low", 32'(p2_irq_b), 32'(0));

    // Rotation 0,1,2,3,0 with all sources available from a fresh reset
    src_avail = 4'b0000;
    do_reset();
    src_avail = 4'b1111;
    write_cfg(5'h0F);
    for (int n = 0; n < 5; n++) begin
      wait_grant("rot");
      check("rot.vec", 32'(vec), 32'(exp_seq[n]));
      ack_pulse();
    end

    // Withdrawal of vec=3 before ack, then search from unchanged ptr
    src_avail = 4'b1000;
    wait_grant("wd");
    check("wd.vec3", 32'(vec), 32'(3));
    src_avail = 4'b0000;
    tick("wd_drop");
    check("wd.irq_high", 32'(p2_irq_b), 32'(1));
    check("wd.vld0", 32'(vec_valid), 32'(0));
    src_avail = 4'b0010;
    tick("wd_regrant");
    check("wd.vec1", 32'(vec), 32'(1));

    // Ack and withdrawal together: treated as ack, ptr advances to 2
    int_ack   = 1'b1;
    src_avail = 4'b0000;
    tick("ack_wd");
    int_ack   = 1'b0;
    src_avail = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick("ack_wd_hold");
      check("ack_wd.hold_irq_high", 32'(p2_irq_b), 32'(1));
    end
    tick("ack_wd_regrant");
    check("ack_wd.vec2", 32'(vec), 32'(2));

    // R3 raises IRQ and NMI together; clearing nmi_en releases only NMI
    src_avail = 4'b0000;
    do_reset();
    src_avail = 4'b0100;
    write_cfg(5'h14);
    tick("nmi_both");
    check("nmi.irq_low", 32'(p2_irq_b), 32'(0));
    check("nmi.nmi_low", 32'(p2_nmi_b), 32'(0));
    write_cfg(5'h04);
    tick("nmi_clear");
    check("nmi.nmi_high", 32'(p2_nmi_b), 32'(1));
    check("nmi.irq_still_low", 32'(p2_irq_b), 32'(0));

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      src_avail = 4'($urandom_range(0, 15));
      int_ack   = ($urandom_range(0, 2) == 0);
      cfg_we    = ($urandom_range(0, 19) == 0);
      cfg_wdata = 5'($urandom_range(0, 31));
      tick("rand");
    end
    int_ack = 1'b0;
    cfg_we  = 1'b0;

    // Asynchronous reset in the middle of an asserted grant
    src_avail = 4'b1111;
    write_cfg(5'h1F);
    wait_grant("arst");
    #2;
    rst_b = 1'b0;
    model_reset();
    #1;
    check("arst.irq_high", 32'(p2_irq_b), 32'(1));
    check("arst.cfg0", 32'(cfg_q), 32'(0));
    check("arst.vld0", 32'(vec_valid), 32'(0));
    check("arst.nmi_high", 32'(p2_nmi_b), 32'(1));
    tick("arst_hold");
    rst_b = 1'b1;
    for (int i = 0; i < 4; i++) tick("arst_nogrant");
    check("arst.no_grant", 32'(p2_irq_b), 32'(1));
    write_cfg(5'h02);
    tick("arst_cfg_grant");
    check("arst.vec1", 32'(vec), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
